// File: rtl/count_sequencer.sv
// count_sequencer: controller for the seven-segment up/down digit counter.
// Runs the counter 0 -> MAX_VAL -> 0 after a start press, parks in HOLD,
// and relaunches an up or down run from the progressive/regressive buttons.
module count_sequencer #(
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27,
    parameter int VAL_W    = 4,
    parameter int MAX_VAL  = 9
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             start,
    input  logic             progressive,
    input  logic             regressive,
    input  logic [VAL_W-1:0] cnt_value,
    output logic             cnt_step,
    output logic             cnt_forward,
    output logic             cnt_clear,
    output logic [1:0]       state,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [VAL_W-1:0]  TOP_VAL   = VAL_W'(MAX_VAL);

    // Button bit order: [0]=start, [1]=progressive, [2]=regressive.
    logic [2:0] pins;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] evt;

    state_t            state_q;
    state_t            state_d;
    logic [TICK_W-1:0] presc_q;
    logic [TICK_W-1:0] presc_d;
    logic              tick;
    logic              step_d;
    logic              clear_d;
    logic              forward_d;
    logic              busy_d;

    assign pins = {regressive, progressive, start};
    assign evt  = sync2 & ~prev;

    // Two-flop synchroniser plus a history flop so a held button yields one rising-edge event.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign tick = ((state_q == UP) || (state_q == DOWN)) && (presc_q == TICK_LAST);

    // Next-state, prescaler and strobe decisions; start outranks everything, and any state change restarts pacing.
    always_comb begin
        state_d   = state_q;
        presc_d   = '0;
        step_d    = 1'b0;
        clear_d   = 1'b0;
        forward_d = cnt_forward;

        if ((state_q == UP) || (state_q == DOWN)) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (evt[0]) begin
            state_d   = UP;
            clear_d   = 1'b1;
            forward_d = 1'b1;
            presc_d   = '0;
        end else begin
            case (state_q)
                UP: begin
                    if (tick) begin
                        if (cnt_value >= TOP_VAL) begin
                            state_d   = DOWN;
                            forward_d = 1'b0;
                        end else begin
                            step_d = 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        if (cnt_value == '0) begin
                            state_d = HOLD;
                        end else begin
                            step_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (evt[1]) begin
                        state_d   = UP;
                        forward_d = 1'b1;
                    end else if (evt[2]) begin
                        state_d   = DOWN;
                        forward_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        if (state_d != state_q) begin
            presc_d = '0;
        end

        busy_d = (state_d == UP) || (state_d == DOWN);
    end

    // State, prescaler and all outputs are registered together so they change on the same edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cnt_step    <= 1'b0;
            cnt_clear   <= 1'b0;
            cnt_forward <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_step    <= step_d;
            cnt_clear   <= clear_d;
            cnt_forward <= forward_d;
            busy        <= busy_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed bench for count_sequencer with a behavioural
// digit counter (TICK_DIV=4, MAX_VAL=3, VAL_W=4).
module tb_count_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       progressive;
    logic       regressive;
    logic [3:0] cnt_value;
    logic       cnt_step;
    logic       cnt_forward;
    logic       cnt_clear;
    logic [1:0] state;
    logic       busy;

    logic [3:0] cnt_model;
    logic       ovr;
    logic [3:0] ovr_val;
    int         checks;
    int         errors;
    int         extra_clears;

    count_sequencer #(
        .TICK_DIV(4),
        .TICK_W  (3),
        .VAL_W   (4),
        .MAX_VAL (3)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .start      (start),
        .progressive(progressive),
        .regressive (regressive),
        .cnt_value  (cnt_value),
        .cnt_step   (cnt_step),
        .cnt_forward(cnt_forward),
        .cnt_clear  (cnt_clear),
        .state      (state),
        .busy       (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural up/down digit counter driven by the sequencer strobes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_model <= 4'd0;
        end else if (cnt_clear) begin
            cnt_model <= 4'd0;
        end else if (cnt_step) begin
            cnt_model <= cnt_forward ? cnt_model + 4'd1 : cnt_model - 4'd1;
        end
    end

    assign cnt_value = ovr ? ovr_val : cnt_model;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        extra_clears = 0;
        ovr          = 1'b0;
        ovr_val      = 4'd0;
        reset        = 1'b1;
        start        = 1'b0;
        progressive  = 1'b0;
        regressive   = 1'b0;

        #2;
        check_output("rst_state", 4'(state), 4'd0);
        check_output("rst_busy", 4'(busy), 4'd0);
        check_output("rst_forward", 4'(cnt_forward), 4'd1);
        check_output("rst_step", 4'(cnt_step), 4'd0);
        check_output("rst_clear", 4'(cnt_clear), 4'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles(2);

        // Full run: one-cycle start pulse, up to 3, down to 0, HOLD.
        $display("[TB] full run");
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(1);
        check_output("s1_still_idle", 4'(state), 4'd0);
        cycles(1);
        check_output("s1_up_state", 4'(state), 4'd1);
        check_output("s1_up_clear", 4'(cnt_clear), 4'd1);
        check_output("s1_up_busy", 4'(busy), 4'd1);
        check_output("s1_up_fwd", 4'(cnt_forward), 4'd1);
        check_output("s1_up_nostep", 4'(cnt_step), 4'd0);
        cycles(3);
        check_output("s1_no_early_step", 4'(cnt_step), 4'd0);
        cycles(1);
        check_output("s1_step_t4", 4'(cnt_step), 4'd1);
        cycles(1);
        check_output("s1_val1", cnt_value, 4'd1);
        check_output("s1_step_1cyc", 4'(cnt_step), 4'd0);
        cycles(3);
        check_output("s1_step_t8", 4'(cnt_step), 4'd1);
        cycles(4);
        check_output("s1_step_t12", 4'(cnt_step), 4'd1);
        cycles(1);
        check_output("s1_val3", cnt_value, 4'd3);
        cycles(3);
        check_output("s1_down_state", 4'(state), 4'd2);
        check_output("s1_down_fwd", 4'(cnt_forward), 4'd0);
        check_output("s1_top_nostep", 4'(cnt_step), 4'd0);
        cycles(4);
        check_output("s1_step_t20", 4'(cnt_step), 4'd1);
        cycles(1);
        check_output("s1_val2", cnt_value, 4'd2);
        cycles(7);
        check_output("s1_step_t28", 4'(cnt_step), 4'd1);
        cycles(1);
        check_output("s1_val0", cnt_value, 4'd0);
        cycles(3);
        check_output("s1_hold_state", 4'(state), 4'd3);
        check_output("s1_hold_busy", 4'(busy), 4'd0);
        check_output("s1_hold_nostep", 4'(cnt_step), 4'd0);

        // HOLD relaunch: both buttons together -> UP without clear.
        $display("[TB] hold relaunch");
        progressive = 1'b1;
        regressive  = 1'b1;
        cycles(2);
        check_output("s3_still_hold", 4'(state), 4'd3);
        cycles(1);
        progressive = 1'b0;
        regressive  = 1'b0;
        check_output("s3_up_state", 4'(state), 4'd1);
        check_output("s3_up_fwd", 4'(cnt_forward), 4'd1);
        check_output("s3_up_noclear", 4'(cnt_clear), 4'd0);
        cycles(4);
        check_output("s3_first_step", 4'(cnt_step), 4'd1);
        cycles(28);
        check_output("s3_hold_again", 4'(state), 4'd3);
        check_output("s3_hold_val0", cnt_value, 4'd0);
        regressive = 1'b1;
        cycles(1);
        regressive = 1'b0;
        cycles(2);
        check_output("s3_down_state", 4'(state), 4'd2);
        check_output("s3_down_fwd", 4'(cnt_forward), 4'd0);
        check_output("s3_down_busy", 4'(busy), 4'd1);
        cycles(4);
        check_output("s3_back_hold", 4'(state), 4'd3);
        check_output("s3_zero_nostep", 4'(cnt_step), 4'd0);

        // Restart mid-run: start event while DOWN at value 2.
        $display("[TB] restart mid-run");
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(2);
        check_output("s4_up_clear", 4'(cnt_clear), 4'd1);
        cycles(16);
        check_output("s4_down", 4'(state), 4'd2);
        cycles(3);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check_output("s4_down_step", 4'(cnt_step), 4'd1);
        check_output("s4_down_step_fwd", 4'(cnt_forward), 4'd0);
        cycles(1);
        check_output("s4_val2", cnt_value, 4'd2);
        cycles(1);
        check_output("s4_restart_state", 4'(state), 4'd1);
        check_output("s4_restart_clear", 4'(cnt_clear), 4'd1);
        check_output("s4_restart_fwd", 4'(cnt_forward), 4'd1);
        check_output("s4_restart_nostep", 4'(cnt_step), 4'd0);
        cycles(1);
        check_output("s4_cleared", cnt_value, 4'd0);
        check_output("s4_clear_1cyc", 4'(cnt_clear), 4'd0);
        cycles(3);
        check_output("s4_step_after4", 4'(cnt_step), 4'd1);
        cycles(1);
        check_output("s4_val1", cnt_value, 4'd1);

        // Async reset between edges while UP with a step pending at value 2.
        $display("[TB] async reset");
        cycles(7);
        check_output("s5_pre_step", 4'(cnt_step), 4'd1);
        check_output("s5_pre_val2", cnt_value, 4'd2);
        #2;
        reset = 1'b1;
        #1;
        check_output("s5_rst_state", 4'(state), 4'd0);
        check_output("s5_rst_busy", 4'(busy), 4'd0);
        check_output("s5_rst_fwd", 4'(cnt_forward), 4'd1);
        check_output("s5_rst_step", 4'(cnt_step), 4'd0);
        check_output("s5_rst_clear", 4'(cnt_clear), 4'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        progressive = 1'b1;
        regressive  = 1'b1;
        cycles(6);
        check_output("s5_idle_ignores", 4'(state), 4'd0);
        progressive = 1'b0;
        regressive  = 1'b0;
        cycles(2);

        // Button held 50 cycles from IDLE gives exactly one restart.
        $display("[TB] held start");
        start = 1'b1;
        cycles(1);
        check_output("s2_no_clear_e1", 4'(cnt_clear), 4'd0);
        cycles(1);
        check_output("s2_no_clear_e2", 4'(cnt_clear), 4'd0);
        cycles(1);
        check_output("s2_clear_e3", 4'(cnt_clear), 4'd1);
        check_output("s2_up_state", 4'(state), 4'd1);
        for (int i = 0; i < 47; i++) begin
            cycles(1);
            if (cnt_clear) extra_clears++;
        end
        check_output("s2_one_clear", 4'(extra_clears), 4'd0);
        check_output("s2_ran_to_hold", 4'(state), 4'd3);
        start = 1'b0;
        cycles(2);

        // Out-of-range value in UP ends the up run without a step.
        $display("[TB] out of range");
        progressive = 1'b1;
        cycles(1);
        progressive = 1'b0;
        cycles(2);
        check_output("s6_up_state", 4'(state), 4'd1);
        check_output("s6_up_noclear", 4'(cnt_clear), 4'd0);
        ovr     = 1'b1;
        ovr_val = 4'd12;
        cycles(4);
        check_output("s6_down_state", 4'(state), 4'd2);
        check_output("s6_nostep", 4'(cnt_step), 4'd0);
        cycles(4);
        check_output("s6_down_step", 4'(cnt_step), 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences the seven-segment up/down digit counter.
- After a start press it runs the counter from 0 up to MAX_VAL, then back down to 0, then parks in HOLD. In HOLD, the progressive or regressive buttons relaunch an up or down run.
- It drives the counter's step, direction and clear controls, paces steps with an internal prescaler, and synchronises/edge-detects the three push-buttons.

Parameters:
TICK_DIV, 100000000, clk_100MHz cycles between counter steps (1 s); minimum 2
TICK_W, 27, prescaler width; must satisfy 2^TICK_W >= TICK_DIV
VAL_W, 4, counter value width
MAX_VAL, 9, top value of the up run

Ports:
clk_100MHz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  raw push-button, asynchronous level
progressive  input  1  raw push-button, asynchronous level
regressive  input  1  raw push-button, asynchronous level
cnt_value  input  VAL_W  current value of the controlled counter
cnt_step  output  1  one-cycle pulse; counter moves one place in cnt_forward direction
cnt_forward  output  1  1 = count up, 0 = count down
cnt_clear  output  1  one-cycle pulse; counter loads 0 synchronously
state  output  2  IDLE=0, UP=1, DOWN=2, HOLD=3
busy  output  1  high while state is UP or DOWN

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state=IDLE, cnt_step=0, cnt_clear=0, cnt_forward=1, busy=0.
  - Prescaler=0; all sync/edge flops=0.
- All outputs are registered.
- Button conditioning, per button:
  - sync1<=pin, sync2<=sync1, prev<=sync2; evt = sync2 & ~prev.
  - A pin that is high before edge k produces evt in the cycle after edge k+1; the FSM acts on it at edge k+2.
  - Holding a button gives exactly one evt.
  - A button held through reset release gives one evt after release.
- Prescaler:
  - Cleared to 0 in IDLE/HOLD and on every state entry, including a restart into UP.
  - In UP/DOWN it increments each cycle. A "tick" occurs at the edge where prescaler == TICK_DIV-1; the prescaler wraps to 0 at that edge.
- FSM transitions, priority top to bottom:
  - start evt in any state: go to UP, cnt_clear=1 for one cycle (first cycle of UP), cnt_forward=1, prescaler cleared.
  - IDLE: hold otherwise.
  - UP, on tick: if cnt_value >= MAX_VAL, go to DOWN with cnt_forward=0 and no step. Otherwise cnt_step=1 for one cycle.
  - DOWN, on tick: if cnt_value == 0, go to HOLD with no step. Otherwise cnt_step=1 for one cycle.
  - HOLD: progressive evt goes to UP (cnt_forward=1, no clear). Regressive evt goes to DOWN (cnt_forward=0). If both fire in the same cycle, UP wins.
  - Progressive/regressive evts in IDLE, UP or DOWN are ignored.
- Output timing:
  - cnt_step and cnt_clear are registered at the deciding edge, are high for exactly one cycle, and are never high together.
  - cnt_forward is valid in the same cycle as any cnt_step.
  - busy = (state==UP || state==DOWN), registered alongside state.
- Counter interface:
  - The counter updates at the edge ending the cnt_step/cnt_clear cycle. With TICK_DIV >= 2, the next decision always sees the updated cnt_value.
  - Out-of-range cnt_value (> MAX_VAL) in UP counts as the end condition. In DOWN it is stepped down normally.
- Run timing: the first tick occurs TICK_DIV cycles after entering UP/DOWN; steps then repeat every TICK_DIV cycles.

Test Plan:
All scenarios use TICK_DIV=4, MAX_VAL=3, VAL_W=4 and a behavioural counter model.
1. Full run: release reset, pulse start for 1 cycle.
   - UP entered at T0, cnt_clear high at T0.
   - cnt_step at T0+4, +8, +12 (value 1,2,3); state=DOWN at T0+16.
   - Steps at T0+20, +24, +28 (value 2,1,0); state=HOLD at T0+32, busy=0.
2. Button sync: hold start high 50 cycles from IDLE.
   - Exactly one cnt_clear, 3 edges after the pin rises.
   - No second restart while the button stays held.
3. HOLD relaunch: from HOLD at value 0, assert progressive and regressive in the same cycle.
   - state=UP, cnt_forward=1, no cnt_clear, first step 4 cycles after entry.
   - Repeat to HOLD, then regressive alone: DOWN entered, next tick (value 0) returns to HOLD with no cnt_step.
4. Restart mid-run: start evt in DOWN at value 2.
   - cnt_clear pulse, state=UP, cnt_forward=1, prescaler restarts; next step 4 cycles later takes value 0 to 1.
5. Async reset mid-run: assert reset between clock edges during UP at value 2.
   - state=IDLE, busy=0, cnt_forward=1, strobes 0 immediately, without waiting for a clock edge.
   - progressive/regressive after release are ignored; only start leaves IDLE.
6. Out-of-range: force cnt_value=12 in UP.
   - Next tick goes to DOWN with no step.
